// File: rtl/ex_div_if.sv
// Handshake/data bundle between the EX stage and the iterative divider.
// The EX stage drives the request side; the divider returns result, ready and busy.
interface ex_div_if;
  logic        start_i;
  logic        annul_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  modport master (
    output start_i, annul_i, op_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// It produces one quotient bit per cycle and applies the sign fix-up in END.
module ex_div (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ZERO = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  // op[0]=1 selects unsigned, op[1]=1 selects remainder
  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_sr;
  logic [1:0]  r_op;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic        r_zero;

  logic        w_start;
  logic        w_in_signed;
  logic [31:0] w_in_dvd_mag;
  logic        w_signed;
  logic [31:0] w_dvs_mag;
  logic [33:0] w_trial;
  logic [64:0] w_step;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_neg_q;
  logic        w_neg_r;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic        w_ready;

  assign w_start      = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;
  assign w_in_signed  = ~bus.op_i[0];
  assign w_in_dvd_mag = (w_in_signed && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i)
                                                            : bus.opdata1_i;

  assign w_signed  = ~r_op[0];
  assign w_dvs_mag = (w_signed && r_divisor[31]) ? (32'd0 - r_divisor) : r_divisor;

  // Shifted partial remainder is r_sr[64:31]; the extra top bit keeps the
  // trial subtraction exact for divisors at or above 2^31.
  assign w_trial = r_sr[64:31] - {2'b00, w_dvs_mag};
  assign w_step  = w_trial[33] ? {r_sr[63:0], 1'b0}
                               : {w_trial[32:0], r_sr[30:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 6'd0;
      r_sr       <= 65'd0;
      r_op       <= 2'd0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op       <= bus.op_i;
            r_dividend <= bus.opdata1_i;
            r_divisor  <= bus.opdata2_i;
            r_cnt      <= 6'd0;
            r_sr       <= {33'd0, w_in_dvd_mag};
            if (bus.opdata2_i == 32'd0) begin
              r_zero  <= 1'b1;
              r_state <= S_ZERO;
            end else begin
              r_zero  <= 1'b0;
              r_state <= S_ON;
            end
          end
        end
        S_ZERO: begin
          if (bus.annul_i) begin
            r_state <= S_IDLE;
          end else begin
            // Divide-by-zero: all-ones quotient, raw dividend as remainder
            r_sr    <= {1'b0, r_dividend, 32'hFFFF_FFFF};
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_sr  <= w_step;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_state <= S_END;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_quot  = r_sr[31:0];
  assign w_rem   = r_sr[63:32];
  // The zero-divisor result is delivered raw, so fix-up is skipped for it
  assign w_neg_q = !r_zero && w_signed && !r_op[1] && (r_dividend[31] ^ r_divisor[31]);
  assign w_neg_r = !r_zero && w_signed &&  r_op[1] && r_dividend[31];

  assign w_quot_fix = w_neg_q ? (32'd0 - w_quot) : w_quot;
  assign w_rem_fix  = w_neg_r ? (32'd0 - w_rem)  : w_rem;

  assign w_ready      = (r_state == S_END);
  assign bus.ready_o  = w_ready;
  assign bus.busy_o   = (r_state == S_ZERO) || (r_state == S_ON);
  assign bus.result_o = !w_ready ? 32'd0 : (r_op[1] ? w_rem_fix : w_quot_fix);

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, divide-by-zero,
// overflow, annul and reset behaviour, checked cycle by cycle.
module tb_ex_div;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ex_div_if bus ();

  ex_div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  function automatic logic [33:0] outs();
    return {bus.ready_o, bus.busy_o, bus.result_o};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed={rdy,busy,res}=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at the falling edge of the first cycle after acceptance.
  task automatic track(input string tag, input logic [31:0] exp, input int lat);
    logic rdy;
    logic bsy;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      rdy = (k == lat);
      bsy = (k < lat);
      chk(tag, outs(), {rdy, bsy, rdy ? exp : 32'h0});
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    track(tag, exp, lat);
    @(negedge clk);
    chk({tag, "_idle"}, outs(), 34'd0);
    $display("op=%0d a=%h b=%h result expected=%h", op, a, b, exp);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b0;
    bus.op_i      = OP_DIVU;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;

    // Reset overrides a pending start
    repeat (3) begin
      @(negedge clk);
      chk("reset", outs(), 34'd0);
    end
    bus.start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset", outs(), 34'd0);

    run_op("div_100_7",     OP_DIV,  32'd100,      32'd7,        32'd14,       33);
    run_op("rem_m7_2",      OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("div_m7_2",      OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("remu_m7_2",     OP_REMU, 32'hFFFFFFF9, 32'd2,        32'd1,        33);
    run_op("divu_by0",      OP_DIVU, 32'h12345678, 32'd0,        32'hFFFFFFFF, 2);
    run_op("rem_by0",       OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2);
    run_op("div_ovf",       OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("rem_ovf",       OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("div_max_m2",    OP_DIV,  32'h7FFFFFFF, 32'hFFFFFFFE, 32'hC0000001, 33);
    run_op("divu_bigdvs",   OP_DIVU, 32'hFFFFFFFF, 32'h80000000, 32'd1,        33);
    run_op("remu_bigdvs",   OP_REMU, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 33);

    // annul in IDLE blocks acceptance
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.op_i = OP_DIVU; bus.opdata1_i = 32'd8; bus.opdata2_i = 32'd2;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    chk("annul_idle", outs(), 34'd0);

    // annul mid-ON, restart right after
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = OP_DIVU; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      chk("annul_on_busy", outs(), {2'b01, 32'h0});
    end
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_on_idle", outs(), 34'd0);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    track("restart_50_5", 32'd10, 33);
    $display("annul then restart DIVU 50/5 expected=0000000a");

    // annul in ZERO: no ready afterwards
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = OP_DIV; bus.opdata1_i = 32'd77; bus.opdata2_i = 32'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("annul_zero_busy", outs(), {2'b01, 32'h0});
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("annul_zero_quiet", outs(), 34'd0);
      @(negedge clk);
    end

    // annul during END leaves the ready pulse intact
    bus.start_i = 1'b1;
    bus.op_i = OP_REMU; bus.opdata1_i = 32'd23; bus.opdata2_i = 32'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("end_annul_busy", outs(), {2'b01, 32'h0});
    @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    chk("end_annul_ready", outs(), {2'b10, 32'd23});
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("end_annul_idle", outs(), 34'd0);

    // start held high through busy and END: only one operation
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = OP_DIV; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    @(negedge clk);
    track("held_start", 32'd14, 33);
    bus.start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_start_idle", outs(), 34'd0);
    end

    // reset mid-operation abandons it
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = OP_DIV; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      chk("rst_mid_busy", outs(), {2'b01, 32'h0});
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_mid_zero", outs(), 34'd0);
    end
    bus.start_i = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("rst_mid_noready", outs(), 34'd0);
    end
    $display("reset mid-op: no ready pulse expected");

    run_op("after_rst", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
